// File: rtl/asrm_status_bank.sv
// asrm_status_bank
// ----------------
// Bank of read-only status registers for ASRM peripherals. Each of the
// N_CH channels is DATA_WIDTH bits wide and has three bus-visible registers:
//   offset i          LIVE[i]   synchronised status_in, read-only
//   offset N_CH+i     STICKY[i] edge events, cleared by a read
//   offset 2*N_CH+i   MASK[i]   interrupt mask, read/write
// Offsets are relative to base_addr. Any other address is not selected.
// data_out is zero in every cycle that is not a selected read, so several
// banks can share an OR-combined read bus.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   enable     bus access strobe, one cycle per access
//   write_en   1 = write, 0 = read (qualified by enable)
//   addr       bus address
//   data_in    write data
//   data_out   registered read data (1-cycle latency)
//   status_in  peripheral status, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   irq        registered OR of (STICKY & MASK) over all channels
module asrm_status_bank #(
    parameter int addr_size   = 16,
    parameter int base_addr   = 0,
    parameter int N_CH        = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       write_en,
    input  logic [addr_size-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    input  logic [N_CH*DATA_WIDTH-1:0] status_in,
    output logic                       irq
);

    localparam int TW   = N_CH * DATA_WIDTH;
    localparam int WARM = SYNC_STAGES + 1;

    logic [TW-1:0]         sync_w;
    logic [DATA_WIDTH-1:0] sync_ch_w  [N_CH];
    logic [DATA_WIDTH-1:0] edge_w     [N_CH];
    logic [DATA_WIDTH-1:0] prev_reg   [N_CH];
    logic [DATA_WIDTH-1:0] sticky_reg [N_CH];
    logic [DATA_WIDTH-1:0] mask_reg   [N_CH];
    logic [N_CH-1:0]       live_sel;
    logic [N_CH-1:0]       sticky_sel;
    logic [N_CH-1:0]       mask_sel;

    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic                  irq_reg, irq_next;
    logic [2:0]            warm_cnt_reg;
    logic                  warm_done;
    logic [addr_size-1:0]  offset;
    logic                  rd_en, wr_en;

    assign offset = addr - addr_size'(base_addr);
    assign rd_en  = enable & ~write_en;
    assign wr_en  = enable & write_en;

    // Input synchroniser (bypassed entirely when SYNC_STAGES == 0).
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_w = status_in;
        end else begin : g_sync
            logic [TW-1:0] sync_reg [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_reg[k] <= '0;
                end else begin
                    sync_reg[0] <= status_in;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_reg[k] <= sync_reg[k-1];
                end
            end
            assign sync_w = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    // Warm-up: edges are ignored until the synchroniser and prev flops have
    // been refilled from live inputs, so levels present at reset release
    // never look like events.
    assign warm_done = (warm_cnt_reg == 3'(WARM));

    always_ff @(posedge clk) begin
        if (!reset) begin
            warm_cnt_reg <= '0;
        end else if (!warm_done) begin
            warm_cnt_reg <= warm_cnt_reg + 3'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] raw_edge;

            assign sync_ch_w[gi] = sync_w[gi*DATA_WIDTH +: DATA_WIDTH];

            if (EDGE_MODE == 0) begin : g_rise
                assign raw_edge = sync_ch_w[gi] & ~prev_reg[gi];
            end else if (EDGE_MODE == 1) begin : g_fall
                assign raw_edge = ~sync_ch_w[gi] & prev_reg[gi];
            end else begin : g_both
                assign raw_edge = sync_ch_w[gi] ^ prev_reg[gi];
            end

            assign edge_w[gi]     = warm_done ? raw_edge : '0;
            assign live_sel[gi]   = (offset == addr_size'(gi));
            assign sticky_sel[gi] = (offset == addr_size'(N_CH + gi));
            assign mask_sel[gi]   = (offset == addr_size'(2*N_CH + gi));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    prev_reg[gi]   <= '0;
                    sticky_reg[gi] <= '0;
                    mask_reg[gi]   <= '0;
                end else begin
                    prev_reg[gi] <= sync_ch_w[gi];
                    // Read-to-clear keeps any event arriving on the same
                    // edge, so set always wins over clear.
                    if (rd_en && sticky_sel[gi])
                        sticky_reg[gi] <= edge_w[gi];
                    else
                        sticky_reg[gi] <= sticky_reg[gi] | edge_w[gi];
                    if (wr_en && mask_sel[gi])
                        mask_reg[gi] <= data_in;
                end
            end
        end
    endgenerate

    // Read mux: at most one select is active, so OR-combining is exact.
    always_comb begin
        data_out_next = '0;
        irq_next      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_en && live_sel[i])   data_out_next = data_out_next | sync_ch_w[i];
            if (rd_en && sticky_sel[i]) data_out_next = data_out_next | sticky_reg[i];
            if (rd_en && mask_sel[i])   data_out_next = data_out_next | mask_reg[i];
            irq_next = irq_next | (|(sticky_reg[i] & mask_reg[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            data_out_reg <= data_out_next;
            irq_reg      <= irq_next;
        end
    end

    assign data_out = data_out_reg;
    assign irq      = irq_reg;

endmodule

// File: doc/asrm_status_bank.md
Name: asrm_status_bank

Overview:
- Parametrised bank of read-only status registers for ASRM peripherals: N_CH channels, each DATA_WIDTH bits.
- Each channel has three registers:
  - a synchronised live status register;
  - a sticky event register, set on edges and cleared on read;
  - a writable interrupt-mask register.
- Sits on the peripheral system bus and drives a single registered irq line to the interrupt controller.

Parameters:
- addr_size, 16, system bus address width.
- base_addr, 0, address of channel 0 live register.
- N_CH, 2, number of status channels (1..16).
- DATA_WIDTH, 8, bits per channel and width of data_in/data_out (1..32).
- SYNC_STAGES, 2, synchroniser flops on status_in (0 = no synchroniser, max 3).
- EDGE_MODE, 0, event type: 0 = rising edge, 1 = falling edge, 2 = both edges.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-low
- enable  input  1  bus access strobe, one cycle per access
- write_en  input  1  qualifies the access as a write (0 = read)
- addr  input  addr_size  bus address
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  read data, registered
- status_in  input  N_CH*DATA_WIDTH  peripheral status; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- irq  output  1  interrupt request, registered

Behaviour:
- Address map, offsets from base_addr:
  - i: LIVE[i], read-only.
  - N_CH+i: STICKY[i], read-to-clear.
  - 2*N_CH+i: MASK[i], read/write.
  - Any other address is not selected.
- Reset (reset == 0 at a clk edge) clears all of the following to 0: data_out, irq, synchroniser flops, previous-value flops, STICKY, MASK, warm-up counter.
- Synchroniser: status_in passes through SYNC_STAGES flops to give sync[i]. LIVE[i] = sync[i].
- Edge detection:
  - prev[i] <= sync[i] every cycle.
  - Per-bit edge by EDGE_MODE: rise = sync & ~prev; fall = ~sync & prev; both = sync ^ prev.
- Warm-up:
  - After reset deasserts, a counter runs SYNC_STAGES+1 cycles.
  - Edge detection is forced to 0 until the count completes.
  - Inputs already high at reset release therefore never create a spurious event.
- Read (enable=1, write_en=0, selected address):
  - data_out <= register value on the next clk edge (1-cycle latency).
  - In every other cycle, including writes and unselected reads, data_out <= 0, so the bus can be OR-combined.
- Read of STICKY[i]:
  - data_out receives STICKY[i] as it was before the edge.
  - At the same edge, STICKY[i] <= edge[i]: bits set by a new event that cycle are kept, so set wins over clear and no event is lost.
- STICKY update in all other cycles: STICKY[i] <= STICKY[i] | edge[i].
- Write (enable=1, write_en=1):
  - To MASK[i]: MASK[i] <= data_in.
  - To LIVE or STICKY: ignored, no side effect.
  - data_out stays 0.
- irq:
  - irq <= OR over all channels of (STICKY[i] & MASK[i]).
  - One cycle after the STICKY/MASK change; no combinational path from inputs.
- Reset during operation takes effect at the next edge and overrides any simultaneous access.
- enable=0 means no side effects, even if addr matches.

Test Plan:
- Reset, then reads of all 3*N_CH addresses -> data_out = 0 each cycle; irq = 0.
- N_CH=2, W=8, SYNC=2: status_in ch1 = 8'hA5, wait 3 cycles, read base+1 -> data_out = 8'hA5 one cycle after the access; data_out = 0 in the following idle cycle.
- EDGE_MODE=0: ch0 bit3 goes 0->1->0, read base+2 -> 8'h08; immediate re-read -> 8'h00.
- Ch0 bit0 rises in the same cycle its STICKY is read -> that read returns the old value (0); the next read returns 8'h01.
- Write MASK[0] (base+4) = 8'h08, then ch0 bit3 rises -> irq = 1 one cycle after STICKY sets. Read STICKY[0] -> irq = 0 one cycle after the clear. Write to base+0 -> LIVE unchanged.
- status_in = all ones held through reset release -> no STICKY bits set and irq stays 0 for 20 cycles. Reset asserted mid-read -> data_out = 0 and MASK = 0.
